// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared opcodes, widths and helpers for the memory stage
package mem_stage_pkg;
    localparam int OPCODE_W  = 4;
    localparam int DATA_W    = 16;
    localparam int REG_IDX_W = 3;
    localparam int ADDR_W    = 8;

    localparam logic [OPCODE_W-1:0] OP_LD = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_ST = 4'b0011;

    function automatic logic is_load(input logic [OPCODE_W-1:0] op);
        return op == OP_LD;
    endfunction

    function automatic logic is_store(input logic [OPCODE_W-1:0] op);
        return op == OP_ST;
    endfunction
endpackage

// File: rtl/mem_stage_data_memory.sv
// rtl/mem_stage_data_memory.sv - DEPTH x 16 data memory, synchronous write and read
module data_memory
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Read returns the pre-edge contents; a store one cycle earlier is already visible.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: load FSM with latency counter and MEM/WB register
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int DEPTH   = 256
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic [DATA_W-1:0]    store_data,
    input  logic [REG_IDX_W-1:0] dest_reg,
    input  logic                 reg_write,
    output logic                 stall,
    output logic                 wb_valid,
    output logic [DATA_W-1:0]    wb_data,
    output logic [REG_IDX_W-1:0] wb_dest,
    output logic                 wb_write_en,
    output logic [OPCODE_W-1:0]  wb_opcode
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]           state;
    logic [2:0]           cnt;
    logic [ADDR_W-1:0]    addr_q;
    logic [REG_IDX_W-1:0] dest_q;
    logic [OPCODE_W-1:0]  op_q;
    logic [ADDR_W-1:0]    rd_addr;
    logic [DATA_W-1:0]    rd_data;
    logic                 ld_go;
    logic                 st_go;
    logic                 unused_addr_hi;

    // Upper address bits intentionally wrap the 256-word space.
    assign unused_addr_hi = ^alu_result[DATA_W-1:ADDR_W];

    assign ld_go   = (state == IDLE) && valid_in && is_load(opcode);
    assign st_go   = (state == IDLE) && valid_in && is_store(opcode);
    assign stall   = (state == IDLE) ? ld_go : (cnt != 3'd0);
    assign rd_addr = (state == IDLE) ? alu_result[ADDR_W-1:0] : addr_q;

    data_memory #(.DEPTH(DEPTH)) u_mem (
        .clock   (clock),
        .wr_en   (st_go && !reset),
        .wr_addr (alu_result[ADDR_W-1:0]),
        .wr_data (store_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            addr_q      <= '0;
            dest_q      <= '0;
            op_q        <= '0;
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_dest     <= '0;
            wb_write_en <= 1'b0;
            wb_opcode   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_go) begin
                        addr_q      <= alu_result[ADDR_W-1:0];
                        dest_q      <= dest_reg;
                        op_q        <= opcode;
                        cnt         <= 3'(MEM_LAT - 1);
                        state       <= WAIT;
                        wb_valid    <= 1'b0;
                        wb_write_en <= 1'b0;
                    end else if (valid_in) begin
                        wb_valid    <= 1'b1;
                        wb_data     <= alu_result;
                        wb_dest     <= dest_reg;
                        wb_opcode   <= opcode;
                        wb_write_en <= st_go ? 1'b0 : reg_write;
                    end else begin
                        wb_valid    <= 1'b0;
                        wb_write_en <= 1'b0;
                    end
                end
                default: begin
                    if (cnt != 3'd0) begin
                        cnt         <= cnt - 3'd1;
                        wb_valid    <= 1'b0;
                        wb_write_en <= 1'b0;
                    end else begin
                        wb_valid    <= 1'b1;
                        wb_data     <= rd_data;
                        wb_dest     <= dest_q;
                        wb_opcode   <= op_q;
                        wb_write_en <= 1'b1;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, load latency in cycles (legal range 1..7).
REQ-002 SHALL have parameter DEPTH, default 256, data-memory words of 16 bits, addressed by alu_result[7:0].
REQ-003 SHALL have port clock  in  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port valid_in  in  1  EX/MEM stage holds a valid instruction.
REQ-006 SHALL have port opcode  in  4  instruction opcode from EX/MEM.
REQ-007 SHALL have port alu_result  in  16  ALU result, used as the memory address for LD/ST.
REQ-008 SHALL have port store_data  in  16  register-file read data 2 (ST payload).
REQ-009 SHALL have port dest_reg  in  3  destination register index.
REQ-010 SHALL have port reg_write  in  1  instruction writes the register file.
REQ-011 SHALL have port stall  out  1  combinational; upstream holds EX/MEM contents while high.
REQ-012 SHALL have port wb_valid  out  1  MEM/WB holds a valid instruction.
REQ-013 SHALL have port wb_data  out  16  write-back value (load data or ALU result).
REQ-014 SHALL have port wb_dest  out  3  destination register index.
REQ-015 SHALL have port wb_write_en  out  1  register-file write enable.
REQ-016 SHALL have port wb_opcode  out  4  propagated opcode.

Function
REQ-017 SHALL use an FSM with states IDLE and WAIT and a 3-bit latency counter cnt.
REQ-018 ALU ops (valid_in=1, opcode not OP_LD/OP_ST) in IDLE: next edge loads wb_valid=1, wb_data=alu_result, wb_dest=dest_reg, wb_write_en=reg_write, wb_opcode=opcode; 1-cycle latency, stall=0.
REQ-019 OP_ST in IDLE: write store_data into mem[alu_result[7:0]] on that edge; next cycle wb_valid=1, wb_write_en=0; stall=0.
REQ-020 OP_LD in IDLE: stall=1 in that cycle; the edge latches address/dest/opcode, sets cnt=MEM_LAT-1 and moves to WAIT.
REQ-021 In WAIT: stall = (cnt!=0); cnt decrements when nonzero; valid_in/opcode are ignored; wb_valid=0 (bubble).
REQ-022 In WAIT with cnt==0: the edge loads wb_data=mem[latched address], wb_dest, wb_opcode, wb_write_en=1, wb_valid=1, and returns to IDLE.
REQ-023 Load timing: stall high for exactly MEM_LAT cycles starting at presentation; load data valid at wb outputs MEM_LAT+1 cycles after presentation.
REQ-024 valid_in=0 in IDLE: next cycle wb_valid=0, wb_write_en=0; other wb fields hold their values.
REQ-025 A load from an address stored by an immediately preceding ST SHALL return the new data (write-before-read).
REQ-026 Address bits [15:8] SHALL be ignored (wrap-around modulo 256).
REQ-027 wb_write_en SHALL never be 1 while wb_valid=0.

Reset
REQ-028 Reset SHALL force state=IDLE, cnt=0, wb_valid=0, wb_data=0, wb_dest=0, wb_write_en=0, wb_opcode=0; stall=0 in the following cycle.
REQ-029 Reset during WAIT SHALL abort the load with no write-back.
REQ-030 Reset SHALL NOT clear memory contents; a ST coinciding with reset SHALL NOT write.

Structure
REQ-031 Shared package SHALL hold OP_LD=4'b0010, OP_ST=4'b0011, OPCODE_W=4, DATA_W=16, REG_IDX_W=3.
REQ-032 Memory SHALL be sub-module data_memory (DEPTH x 16, synchronous write, synchronous read); FSM, counter and MEM/WB register SHALL reside in mem_stage.

Verification
REQ-033 ALU op alu_result=16'h1234, dest=5, reg_write=1 -> one cycle later wb_valid=1, wb_data=16'h1234, wb_dest=5, wb_write_en=1; stall never high.
REQ-034 ST addr 16'h0010 data 16'hBEEF, then LD addr 16'h0010 -> stall high 2 cycles; wb_data=16'hBEEF, wb_write_en=1 3 cycles after LD presented.
REQ-035 ST to 16'h01FF data 16'h00AA, LD from 16'h00FF -> wb_data=16'h00AA (wrap).
REQ-036 Reset asserted in the 2nd cycle of a LD -> next cycle stall=0, wb_valid=0, wb_write_en=0; memory retains earlier ST data.
REQ-037 MEM_LAT=1: LD -> stall high 1 cycle, data at wb 2 cycles after presentation; back-to-back LD, ALU op sequence with no lost or duplicated wb_valid pulse.
